pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16: number of cycles pll_rst_n is held low per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 4096: maximum cycles allowed in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter STABLE_CYC, default 256: number of consecutive locked cycles required before reset release.
REQ-004 SHALL have parameter STAGE_GAP_CYC, default 8: cycles between core_rst_n release and dp_rst_n release.
REQ-005 SHALL have parameter MAX_RETRY, default 3: number of failed lock attempts before entering FAIL.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, free-running reference (not PLL-derived).
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1 bit: PLL lock status, asynchronous to clk.
REQ-009 SHALL have port sw_rst_req, input, 1 bit: single-cycle software reset request.
REQ-010 SHALL have port pll_rst_n, output, 1 bit: active-low reset driven back to the PLL.
REQ-011 SHALL have port core_rst_n, output, 1 bit: first-stage domain reset.
REQ-012 SHALL have port dp_rst_n, output, 1 bit: second-stage datapath reset.
REQ-013 SHALL have port locked_ok, output, 1 bit: high only in RUN.
REQ-014 SHALL have port fail, output, 1 bit: high only in FAIL.
REQ-015 SHALL have port retry_cnt, output, 4 bits: failed attempts since the last RUN entry.
REQ-016 SHALL have port loss_cnt, output, 16 bits: lock-loss events in RUN, saturating.

Function
REQ-017 SHALL synchronize pll_locked through a 2-FF synchronizer (locked_s), so locked_s lags pll_locked by 2 cycles; all outputs SHALL be registered.
REQ-018 SHALL implement FSM states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
REQ-019 In PLL_RST, pll_rst_n=0, core_rst_n=0 and dp_rst_n=0; after exactly RST_PULSE_CYC cycles the FSM SHALL enter WAIT_LOCK.
REQ-020 In WAIT_LOCK, pll_rst_n=1; locked_s=1 SHALL move to STABLE; after LOCK_TIMEOUT_CYC cycles without lock, retry_cnt SHALL increment, and the FSM SHALL go to FAIL if the new value equals MAX_RETRY, else to PLL_RST.
REQ-021 In STABLE, locked_s SHALL stay high for STABLE_CYC consecutive cycles before RELEASE; any low cycle SHALL return to WAIT_LOCK with its timer restarted and retry_cnt unchanged.
REQ-022 On RELEASE entry, core_rst_n SHALL go to 1; STAGE_GAP_CYC cycles later, dp_rst_n SHALL go to 1 and the FSM SHALL enter RUN.
REQ-023 On RUN entry, retry_cnt SHALL clear to 0.
REQ-024 locked_s falling in RELEASE or RUN SHALL drive core_rst_n and dp_rst_n to 0 on the next cycle and enter PLL_RST; in RUN, loss_cnt SHALL increment, saturating at 0xFFFF.
REQ-025 sw_rst_req in any state other than FAIL SHALL enter PLL_RST next cycle, with all resets low and the PLL_RST timer restarted.
REQ-026 sw_rst_req in FAIL SHALL clear retry_cnt and enter PLL_RST.
REQ-027 In FAIL, pll_rst_n, core_rst_n and dp_rst_n SHALL all be held at 0, and lock activity SHALL be ignored.
REQ-028 sw_rst_req coinciding with a lock loss in RUN SHALL produce one PLL_RST entry, and loss_cnt SHALL increment by 1.
REQ-029 dp_rst_n SHALL never be 1 while core_rst_n is 0.

Reset
REQ-030 SHALL set, on rst_n low asynchronously: state PLL_RST, pll_rst_n=0, core_rst_n=0, dp_rst_n=0, locked_ok=0, fail=0, retry_cnt=0, loss_cnt=0, all timers 0, synchronizer flops 0.
REQ-031 Reset mid-operation SHALL abort any state; after rst_n deasserts, behaviour SHALL restart from PLL_RST with a full RST_PULSE_CYC pulse.

Structure
REQ-032 SHALL place the state enum pll_sup_state_t and the default parameter constants in package pll_sup_pkg.
REQ-033 SHALL use one sub-module, sync_bit (2-FF synchronizer, async active-low reset), for pll_locked.
REQ-034 SHALL use a single shared down-counter timer reloaded on each state entry, sized by $clog2 of the largest parameter.

Verification
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, STABLE_CYC=8, STAGE_GAP_CYC=4, MAX_RETRY=3.
REQ-035 Nominal: pll_locked rises 10 cycles after pll_rst_n rises -> core_rst_n=1 exactly 2+8 cycles later, dp_rst_n=1 4 cycles after that, locked_ok=1, retry_cnt=0.
REQ-036 No lock: pll_locked held 0 -> three 4-cycle pll_rst_n pulses spaced by 32 cycles, then fail=1, retry_cnt=3, all resets 0; sw_rst_req -> fail=0, retry_cnt=0, a new pulse.
REQ-037 Glitch in STABLE: pll_locked low for 1 cycle after 5 locked cycles -> return to WAIT_LOCK, retry_cnt unchanged, a fresh 8-cycle stable window required.
REQ-038 Lock loss in RUN: pll_locked falls -> resets low 3 cycles later, loss_cnt 0->1, pll_rst_n low for 4 cycles; force loss_cnt=0xFFFF then lose lock -> stays 0xFFFF.
REQ-039 Simultaneous: sw_rst_req in the same cycle locked_s falls in RUN -> single PLL_RST entry, loss_cnt +1.
REQ-040 Async reset: assert rst_n mid-RELEASE -> all outputs at reset values immediately, no clk edge needed; check dp_rst_n never 1 while core_rst_n=0 via assertion throughout.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } pll_sup_state_t;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 4096;
    localparam int DEF_STABLE_CYC       = 256;
    localparam int DEF_STAGE_GAP_CYC    = 8;
    localparam int DEF_MAX_RETRY        = 3;

    function automatic int pll_sup_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and staged core/datapath reset release,
// with bounded lock retries, a sticky FAIL state and a saturating lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        sw_rst_req,
    output logic        pll_rst_n,
    output logic        core_rst_n,
    output logic        dp_rst_n,
    output logic        locked_ok,
    output logic        fail,
    output logic [3:0]  retry_cnt,
    output logic [15:0] loss_cnt
);

    localparam int TMR_MAX = pll_sup_max4(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC, STAGE_GAP_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // The timer holds the cycles remaining after the current one. The first cycle after
    // reset counts toward the PLL pulse, and the lock-detect cycle in WAIT_LOCK counts as
    // the first stable cycle, hence the -2 reloads (RST_PULSE_CYC, STABLE_CYC >= 2).
    localparam logic [TMR_W-1:0] LD_RST    = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] LD_BOOT   = TMR_W'(RST_PULSE_CYC - 2);
    localparam logic [TMR_W-1:0] LD_LOCK   = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LD_STABLE = TMR_W'(STABLE_CYC - 2);
    localparam logic [TMR_W-1:0] LD_GAP    = TMR_W'(STAGE_GAP_CYC - 1);

    pll_sup_state_t   r_state;
    pll_sup_state_t   w_nxt_state;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_nxt_timer;
    logic             r_boot;
    logic [3:0]       r_retry_cnt;
    logic [3:0]       w_nxt_retry;
    logic [3:0]       w_retry_inc;
    logic [15:0]      r_loss_cnt;
    logic             w_loss_evt;
    logic             w_locked_s;
    logic             w_tmr_zero;
    logic             r_pll_rst_n;
    logic             r_core_rst_n;
    logic             r_dp_rst_n;
    logic             r_locked_ok;
    logic             r_fail;

    sync_bit u_sync_locked (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_tmr_zero  = (r_timer == '0);
    assign w_retry_inc = r_retry_cnt + 4'd1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer - TMR_W'(1);
        w_nxt_retry = r_retry_cnt;
        w_loss_evt  = 1'b0;
        if (r_boot) begin
            w_nxt_state = ST_PLL_RST;
            w_nxt_timer = LD_BOOT;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (w_tmr_zero) begin
                        w_nxt_state = ST_WAIT_LOCK;
                        w_nxt_timer = LD_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_nxt_state = ST_STABLE;
                        w_nxt_timer = LD_STABLE;
                    end else if (w_tmr_zero) begin
                        w_nxt_retry = w_retry_inc;
                        if (w_retry_inc == 4'(MAX_RETRY)) begin
                            w_nxt_state = ST_FAIL;
                            w_nxt_timer = '0;
                        end else begin
                            w_nxt_state = ST_PLL_RST;
                            w_nxt_timer = LD_RST;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_nxt_state = ST_WAIT_LOCK;
                        w_nxt_timer = LD_LOCK;
                    end else if (w_tmr_zero) begin
                        w_nxt_state = ST_RELEASE;
                        w_nxt_timer = LD_GAP;
                    end
                end
                ST_RELEASE: begin
                    if (!w_locked_s) begin
                        w_nxt_state = ST_PLL_RST;
                        w_nxt_timer = LD_RST;
                    end else if (w_tmr_zero) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_timer = '0;
                        w_nxt_retry = 4'd0;
                    end
                end
                ST_RUN: begin
                    w_nxt_timer = '0;
                    if (!w_locked_s) begin
                        w_loss_evt  = 1'b1;
                        w_nxt_state = ST_PLL_RST;
                        w_nxt_timer = LD_RST;
                    end
                end
                ST_FAIL: begin
                    w_nxt_timer = '0;
                    if (sw_rst_req) begin
                        w_nxt_retry = 4'd0;
                        w_nxt_state = ST_PLL_RST;
                        w_nxt_timer = LD_RST;
                    end
                end
                default: begin
                    w_nxt_state = ST_PLL_RST;
                    w_nxt_timer = LD_RST;
                end
            endcase
        end
        // Software request wins over any pending transition; a coincident lock loss is still counted.
        if (sw_rst_req && (r_state != ST_FAIL)) begin
            w_nxt_state = ST_PLL_RST;
            w_nxt_timer = LD_RST;
            w_nxt_retry = r_retry_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PLL_RST;
            r_timer      <= '0;
            r_boot       <= 1'b1;
            r_retry_cnt  <= 4'd0;
            r_loss_cnt   <= 16'd0;
            r_pll_rst_n  <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_dp_rst_n   <= 1'b0;
            r_locked_ok  <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_boot       <= 1'b0;
            r_state      <= w_nxt_state;
            r_timer      <= w_nxt_timer;
            r_retry_cnt  <= w_nxt_retry;
            if (w_loss_evt && (r_loss_cnt != 16'hFFFF)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
            r_pll_rst_n  <= !((w_nxt_state == ST_PLL_RST) || (w_nxt_state == ST_FAIL));
            r_core_rst_n <= (w_nxt_state == ST_RELEASE) || (w_nxt_state == ST_RUN);
            r_dp_rst_n   <= (w_nxt_state == ST_RUN);
            r_locked_ok  <= (w_nxt_state == ST_RUN);
            r_fail       <= (w_nxt_state == ST_FAIL);
        end
    end

    assign pll_rst_n  = r_pll_rst_n;
    assign core_rst_n = r_core_rst_n;
    assign dp_rst_n   = r_dp_rst_n;
    assign locked_ok  = r_locked_ok;
    assign fail       = r_fail;
    assign retry_cnt  = r_retry_cnt;
    assign loss_cnt   = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random lock/sw traffic
// compared every cycle against a phase/age reference model.
module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_STB = 8;
    localparam int P_GAP = 4;
    localparam int P_MR  = 3;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_REL  = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_FAIL = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pll_locked = 1'b0;
    logic        sw_rst_req = 1'b0;
    logic        pll_rst_n;
    logic        core_rst_n;
    logic        dp_rst_n;
    logic        locked_ok;
    logic        fail;
    logic [3:0]  retry_cnt;
    logic [15:0] loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: phase, cycles spent in it, consecutive synchronized-lock streak, counters.
    int   m_ph;
    int   m_age;
    int   m_streak;
    int   m_retry;
    int   m_loss;
    logic m_s1;
    logic m_s2;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (P_RST),
        .LOCK_TIMEOUT_CYC (P_TO),
        .STABLE_CYC       (P_STB),
        .STAGE_GAP_CYC    (P_GAP),
        .MAX_RETRY        (P_MR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .pll_rst_n  (pll_rst_n),
        .core_rst_n (core_rst_n),
        .dp_rst_n   (dp_rst_n),
        .locked_ok  (locked_ok),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_RST;
        m_age = 0;
        m_streak = 0;
        m_retry = 0;
        m_loss = 0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
    endtask

    task automatic model_step(input logic lk, input logic sw);
        logic ls;
        int   nph;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        m_age++;
        nph = m_ph;
        if (sw && (m_ph != PH_FAIL)) begin
            if ((m_ph == PH_RUN) && !ls && (m_loss < 65535)) m_loss++;
            nph = PH_RST;
            m_age = 0;
        end else begin
            case (m_ph)
                PH_RST:  if (m_age >= P_RST) nph = PH_WAIT;
                PH_WAIT: begin
                    if (ls) begin
                        nph = PH_STB;
                        m_streak = 1;
                    end else if (m_age >= P_TO) begin
                        m_retry++;
                        nph = (m_retry == P_MR) ? PH_FAIL : PH_RST;
                    end
                end
                PH_STB: begin
                    if (!ls) nph = PH_WAIT;
                    else begin
                        m_streak++;
                        if (m_streak >= P_STB) nph = PH_REL;
                    end
                end
                PH_REL: begin
                    if (!ls) nph = PH_RST;
                    else if (m_age >= P_GAP) begin
                        nph = PH_RUN;
                        m_retry = 0;
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        if (m_loss < 65535) m_loss++;
                        nph = PH_RST;
                    end
                end
                default: begin
                    if (sw) begin
                        m_retry = 0;
                        nph = PH_RST;
                    end
                end
            endcase
        end
        if (nph != m_ph) m_age = 0;
        m_ph = nph;
    endtask

    task automatic compare_all();
        chk("pll_rst_n", pll_rst_n, (m_ph != PH_RST) && (m_ph != PH_FAIL));
        chk("core_rst_n", core_rst_n, (m_ph == PH_REL) || (m_ph == PH_RUN));
        chk("dp_rst_n", dp_rst_n, m_ph == PH_RUN);
        chk("locked_ok", locked_ok, m_ph == PH_RUN);
        chk("fail", fail, m_ph == PH_FAIL);
        chk("retry_cnt", retry_cnt, m_retry);
        chk("loss_cnt", loss_cnt, m_loss);
        chk("order_dp_core", dp_rst_n & ~core_rst_n, 0);
    endtask

    // Called before a rising edge; returns at the following falling edge after checking.
    task automatic step(input logic lk, input logic sw);
        pll_locked = lk;
        sw_rst_req = sw;
        @(posedge clk);
        model_step(lk, sw);
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps_until_prst_high(input logic lk, output int n);
        n = 0;
        while ((pll_rst_n !== 1'b1) && (n < 100)) begin
            step(lk, 1'b0);
            n++;
        end
    endtask

    task automatic run_to_run(input string tag);
        int n;
        n = 0;
        while ((locked_ok !== 1'b1) && (n < 200)) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk(tag, locked_ok, 1);
    endtask

    initial begin
        int n;
        logic v;
        int len;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        compare_all();
        #2 rst_n = 1'b1;

        // Nominal bring-up
        steps_until_prst_high(1'b0, n);
        chk("boot_pulse_len", n, P_RST);
        repeat (9) step(1'b0, 1'b0);
        n = 0;
        while ((core_rst_n !== 1'b1) && (n < 50)) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("nom_core_latency", n, 10);
        n = 0;
        while ((dp_rst_n !== 1'b1) && (n < 50)) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("nom_dp_gap", n, P_GAP);
        chk("nom_locked_ok", locked_ok, 1);
        chk("nom_retry", retry_cnt, 0);

        // Lock loss in RUN
        n = 0;
        while ((core_rst_n !== 1'b0) && (n < 20)) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("loss_core_latency", n, 3);
        chk("loss_dp_low", dp_rst_n, 0);
        chk("loss_cnt_one", loss_cnt, 1);
        steps_until_prst_high(1'b0, n);
        chk("loss_prst_len", n, P_RST);

        // No lock at all: retries exhaust into FAIL
        repeat (110) step(1'b0, 1'b0);
        chk("nolock_fail", fail, 1);
        chk("nolock_retry", retry_cnt, P_MR);
        chk("nolock_prst", pll_rst_n, 0);
        chk("nolock_core", core_rst_n, 0);
        step(1'b0, 1'b1);
        chk("fail_exit_fail", fail, 0);
        chk("fail_exit_retry", retry_cnt, 0);
        chk("fail_exit_prst", pll_rst_n, 0);

        // One-cycle glitch during the stable window
        steps_until_prst_high(1'b0, n);
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n = 0;
        while ((core_rst_n !== 1'b1) && (n < 50)) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("glitch_fresh_window", n, 10);
        chk("glitch_retry", retry_cnt, 0);
        run_to_run("glitch_run");

        // Software reset coinciding with synchronized lock loss
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("simul_loss", loss_cnt, 2);
        chk("simul_core", core_rst_n, 0);
        steps_until_prst_high(1'b1, n);
        chk("simul_single_pulse", n, P_RST);
        run_to_run("simul_run");

        // Saturation of the loss counter
        force dut.r_loss_cnt = 16'hFFFF;
        m_loss = 65535;
        step(1'b1, 1'b0);
        release dut.r_loss_cnt;
        repeat (4) step(1'b0, 1'b0);
        chk("loss_saturate", loss_cnt, 16'hFFFF);
        run_to_run("sat_run");

        // Random lock / software-reset traffic
        for (int s = 0; s < 60; s++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            for (int k = 0; k < len; k++) begin
                step(v, ($urandom_range(0, 99) == 0));
            end
        end

        // Asynchronous reset in the middle of RELEASE
        step(1'b0, 1'b1);
        steps_until_prst_high(1'b1, n);
        n = 0;
        while ((core_rst_n !== 1'b1) && (n < 50)) begin
            step(1'b1, 1'b0);
            n++;
        end
        step(1'b1, 1'b0);
        chk("arst_in_release", core_rst_n & ~dp_rst_n, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_prst", pll_rst_n, 0);
        chk("arst_core", core_rst_n, 0);
        chk("arst_dp", dp_rst_n, 0);
        chk("arst_ok", locked_ok, 0);
        chk("arst_fail", fail, 0);
        chk("arst_retry", retry_cnt, 0);
        chk("arst_loss", loss_cnt, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        steps_until_prst_high(1'b1, n);
        chk("arst_full_pulse", n, P_RST);
        run_to_run("arst_run");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
